traffic_phase_timer: RTL and testbench

TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

---
 rtl/traffic_pkg.sv | 39 +++
 rtl/traffic_phase_timer_phase_cnt.sv | 29 ++
 rtl/traffic_phase_timer.sv | 129 ++++++++++++
 tb/tb_traffic_phase_timer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Phase codes and lamp-word bit ordering shared by the phase timer and the
// downstream NS/EW lamp controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        PED_WALK  = 3'd6
    } phase_e;

    localparam int LAMP_W  = 7;
    localparam int LB_EW_R = 0;
    localparam int LB_EW_Y = 1;
    localparam int LB_EW_G = 2;
    localparam int LB_NS_R = 3;
    localparam int LB_NS_Y = 4;
    localparam int LB_NS_G = 5;
    localparam int LB_WALK = 6;

    // Unknown codes decode to all-red so the lamps fail safe.
    function automatic logic [LAMP_W-1:0] lamps_of(input phase_e p);
        logic [LAMP_W-1:0] l;
        l = '0;
        case (p)
            NS_GREEN:  begin l[LB_NS_G] = 1'b1; l[LB_EW_R] = 1'b1; end
            NS_YELLOW: begin l[LB_NS_Y] = 1'b1; l[LB_EW_R] = 1'b1; end
            EW_GREEN:  begin l[LB_NS_R] = 1'b1; l[LB_EW_G] = 1'b1; end
            EW_YELLOW: begin l[LB_NS_R] = 1'b1; l[LB_EW_Y] = 1'b1; end
            PED_WALK:  begin l[LB_NS_R] = 1'b1; l[LB_EW_R] = 1'b1; l[LB_WALK] = 1'b1; end
            default:   begin l[LB_NS_R] = 1'b1; l[LB_EW_R] = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_timer_phase_cnt.sv
// Per-phase tick counter: synchronous clear on phase entry, tick-gated count,
// terminal compare against the current phase's last tick index.
module phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_term,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_tick)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/traffic_phase_timer.sv
// Two-axis traffic phase sequencer with pedestrian walk insertion; all lamp
// and status outputs are registered alongside the state.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] phase,
    output logic       phase_chg,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       walk
);

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);

    phase_e              r_state;
    logic                r_ped_pending;
    logic                r_dir_ew;
    logic                r_ped_ack;
    logic                r_phase_chg;
    logic [LAMP_W-1:0]   r_lamps;

    phase_e              w_next;
    logic [CNT_W-1:0]    w_term;
    logic [CNT_W-1:0]    w_cnt;
    logic                w_tc;
    logic                w_clr;
    logic                w_enter_walk;

    always_comb begin
        w_term = GMAX_M1;
        case (r_state)
            NS_YELLOW, EW_YELLOW: w_term = YEL_M1;
            ALL_RED_A, ALL_RED_B: w_term = AR_M1;
            PED_WALK:             w_term = WALK_M1;
            default:              w_term = GMAX_M1;
        endcase
    end

    phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_tick (tick),
        .i_term (w_term),
        .o_cnt  (w_cnt),
        .o_tc   (w_tc)
    );

    // Greens may leave early once the minimum has elapsed and someone is waiting.
    always_comb begin
        w_next = r_state;
        case (r_state)
            NS_GREEN:
                if (tick && (w_tc || (w_cnt >= GMIN_M1 && (ew_req || r_ped_pending))))
                    w_next = NS_YELLOW;
            NS_YELLOW: if (tick && w_tc) w_next = ALL_RED_A;
            ALL_RED_A: if (tick && w_tc) w_next = r_ped_pending ? PED_WALK : EW_GREEN;
            EW_GREEN:
                if (tick && (w_tc || (w_cnt >= GMIN_M1 && (ns_req || r_ped_pending))))
                    w_next = EW_YELLOW;
            EW_YELLOW: if (tick && w_tc) w_next = ALL_RED_B;
            ALL_RED_B: if (tick && w_tc) w_next = r_ped_pending ? PED_WALK : NS_GREEN;
            PED_WALK:  if (tick && w_tc) w_next = r_dir_ew ? EW_GREEN : NS_GREEN;
            default:   w_next = ALL_RED_B;
        endcase
    end

    assign w_clr        = (w_next != r_state);
    assign w_enter_walk = (w_next == PED_WALK) && (r_state != PED_WALK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= NS_GREEN;
            r_ped_pending <= 1'b0;
            r_dir_ew      <= 1'b0;
            r_ped_ack     <= 1'b0;
            r_phase_chg   <= 1'b0;
            r_lamps       <= lamps_of(NS_GREEN);
        end else begin
            r_state     <= w_next;
            r_phase_chg <= w_clr;
            r_ped_ack   <= w_enter_walk;
            r_lamps     <= lamps_of(w_next);
            // A press on the walk entry edge is served by that walk.
            if (w_enter_walk)
                r_ped_pending <= 1'b0;
            else if (ped_req && r_state != PED_WALK)
                r_ped_pending <= 1'b1;
            if (r_state == ALL_RED_A && w_clr)
                r_dir_ew <= 1'b1;
            else if (r_state == ALL_RED_B && w_clr)
                r_dir_ew <= 1'b0;
        end
    end

    assign phase     = r_state;
    assign phase_chg = r_phase_chg;
    assign ped_ack   = r_ped_ack;
    assign ns_g      = r_lamps[LB_NS_G];
    assign ns_y      = r_lamps[LB_NS_Y];
    assign ns_r      = r_lamps[LB_NS_R];
    assign ew_g      = r_lamps[LB_EW_G];
    assign ew_y      = r_lamps[LB_EW_Y];
    assign ew_r      = r_lamps[LB_EW_R];
    assign walk      = r_lamps[LB_WALK];

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Randomized and directed bench for traffic_phase_timer: a tick-level phase
// model feeds a queue of expected outputs that a monitor checks every clk.
module tb_traffic_phase_timer;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 10;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0, ns_req = 1'b0, ew_req = 1'b0, ped_req = 1'b0;
    logic ped_ack, phase_chg, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk;
    logic [2:0] phase;

    traffic_phase_timer dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ns_req(ns_req), .ew_req(ew_req),
        .ped_req(ped_req), .ped_ack(ped_ack), .phase(phase), .phase_chg(phase_chg),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
        .walk(walk)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ph;
        logic [6:0] lamps;
        logic       chg;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0, n_bad = 0;
    int chg_seen = 0, ack_seen = 0, walk_seen = 0;

    // {walk, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} per phase code
    logic [6:0] lamp_tbl [7] = '{7'b0100001, 7'b0010001, 7'b0001001, 7'b0001100,
                                 7'b0001010, 7'b0001001, 7'b1001001};

    int m_ph = 0, m_cnt = 0, m_next_green = 0;
    bit m_pend = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] lamps_now();
        return {walk, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("phase", int'(phase), e.ph);
                chk("lamps", int'(lamps_now()), int'(e.lamps));
                chk("phase_chg", int'(phase_chg), int'(e.chg));
                chk("ped_ack", int'(ped_ack), int'(e.ack));
            end
            chk("ns_one_lamp", int'(ns_g) + int'(ns_y) + int'(ns_r), 1);
            chk("ew_one_lamp", int'(ew_g) + int'(ew_y) + int'(ew_r), 1);
            chk("greens_exclusive", int'(ns_g & ew_g), 0);
            chg_seen  += int'(phase_chg);
            ack_seen  += int'(ped_ack);
            walk_seen += int'(walk);
        end
    end

    function automatic int dur_of(input int ph);
        case (ph)
            1, 4:    return YELLOW_T;
            2, 5:    return ALLRED_T;
            6:       return WALK_T;
            default: return GREEN_MAX;
        endcase
    endfunction

    // One clk of stimulus; the model advances by whole ticks in a phase.
    task automatic cyc(input logic t, input logic n, input logic e, input logic p);
        int  nxt, ticks_done;
        bit  over, waiting;
        exp_t x;
        @(negedge clk);
        rst_n = 1'b1;
        tick = t; ns_req = n; ew_req = e; ped_req = p;
        nxt = m_ph;
        if (t) begin
            ticks_done = m_cnt + 1;
            over = (ticks_done == dur_of(m_ph));
            if (m_ph == 0 || m_ph == 3) begin
                waiting = m_pend || (m_ph == 0 ? e : n);
                if (over || (ticks_done >= GREEN_MIN && waiting)) nxt = m_ph + 1;
            end else if (over) begin
                case (m_ph)
                    1, 4: nxt = m_ph + 1;
                    2:    begin m_next_green = 3; nxt = m_pend ? 6 : 3; end
                    5:    begin m_next_green = 0; nxt = m_pend ? 6 : 0; end
                    default: nxt = m_next_green;
                endcase
            end
        end
        x.ph = nxt; x.lamps = lamp_tbl[nxt];
        x.chg = (nxt != m_ph); x.ack = (nxt == 6 && m_ph != 6);
        if (x.ack) m_pend = 0;
        else if (p && m_ph != 6) m_pend = 1;
        m_cnt = (nxt != m_ph) ? 0 : m_cnt + int'(t);
        m_ph = nxt;
        q.push_back(x);
    endtask

    task automatic do_reset();
        exp_t x;
        @(negedge clk);
        rst_n = 1'b0;
        tick = 0; ns_req = 0; ew_req = 0; ped_req = 0;
        #1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_lamps", int'(lamps_now()), int'(lamp_tbl[0]));
        chk("rst_chg", int'(phase_chg), 0);
        chk("rst_ack", int'(ped_ack), 0);
        m_ph = 0; m_cnt = 0; m_pend = 0; m_next_green = 0;
        x.ph = 0; x.lamps = lamp_tbl[0]; x.chg = 0; x.ack = 0;
        q.push_back(x);
    endtask

    initial begin
        int c0, a0, w0, k;
        bit rn, re;

        // no requests: 10+2+1+10 then EW_YELLOW
        do_reset();
        c0 = chg_seen;
        repeat (25) cyc(1, 0, 0, 0);
        chk("idle_chg_count", chg_seen - c0, 4);

        // cross-direction requests shorten the greens to GREEN_MIN
        do_reset();
        repeat (7) cyc(1, 0, 1, 0);
        repeat (12) cyc(1, 1, 0, 0);

        // pedestrian pulse early in NS_GREEN
        do_reset();
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        a0 = ack_seen; w0 = walk_seen;
        cyc(1, 0, 0, 1);
        repeat (30) cyc(1, 0, 0, 0);
        chk("ped_ack_count", ack_seen - a0, 1);
        chk("walk_cycles", walk_seen - w0, WALK_T);

        // press during the walk is dropped
        do_reset();
        a0 = ack_seen;
        cyc(1, 0, 0, 1);
        k = 0;
        while (m_ph != 6 && k < 100) begin cyc(1, 0, 0, 0); k++; end
        chk("reach_walk", int'(m_ph == 6), 1);
        cyc(1, 0, 0, 1);
        repeat (40) cyc(1, 0, 0, 0);
        chk("single_walk_ack", ack_seen - a0, 1);

        // slow time base: tick every third clk
        do_reset();
        for (int i = 0; i < 45; i++) cyc(i % 3 == 0, 0, 0, 0);

        // reset while in EW_YELLOW
        do_reset();
        k = 0;
        while (m_ph != 4 && k < 200) begin cyc(1, 0, 0, 0); k++; end
        chk("reach_ew_yellow", int'(m_ph == 4), 1);
        cyc(1, 0, 0, 0);
        do_reset();
        repeat (5) cyc(1, 0, 0, 0);

        // random traffic
        rn = 0; re = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) rn = ~rn;
            if ($urandom_range(9) == 0) re = ~re;
            cyc($urandom_range(9) < 6, rn, re, $urandom_range(29) == 0);
            if (i == 1500) do_reset();
        end

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
